// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: framed command responder on the parallel side of a UART.
// Hunts for a request frame (A5, LEN, payload, CSUM), checks the length and
// the XOR checksum, then echoes the frame (5A, LEN, payload, CSUM) or sends a
// two-byte NAK (EE, code) through the transmitter handshake.
//
// Ports:
//   clk, reset    system clock, synchronous active-low reset
//   rx_done_tick  received-byte strobe, r_data valid in the same cycle
//   r_data        received byte
//   tx_done_tick  transmitter finished the current byte
//   tx_start      one-cycle request to transmit w_data
//   w_data        byte to transmit, held until the matching tx_done_tick
//   busy          high from accepted header byte until the response completes
//   frame_ok      pulse when a valid frame is accepted
//   frame_err     pulse on length error, checksum error or inter-byte timeout
//
// Optional feature: define UART_RESP_TIMEOUT_EN to abort a partial frame after
// TIMEOUT idle cycles; without it TIMEOUT is unused and partial frames wait.
module uart_cmd_responder #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] r_data,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] SOF_REQ  = 8'hA5;
  localparam logic [7:0] SOF_RSP  = 8'h5A;
  localparam logic [7:0] SOF_NAK  = 8'hEE;
  localparam logic [7:0] NAK_CSUM = 8'h01;
  localparam logic [7:0] NAK_LEN  = 8'h02;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_param_check
    $error("uart_cmd_responder: MAX_LEN must be 1..255 and TIMEOUT at least 1");
  end

  // The first response byte is launched on the same edge that accepts the
  // final request byte, so the response and NAK phases share one wait state.
  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_TXWAIT
  } state_t;

  state_t           state;
  logic [7:0]       len;
  logic [7:0]       xsum;
  logic [IDX_W-1:0] idx;
  logic [8:0]       tx_cnt;
  logic             nak;
  logic [7:0]       nak_code;
  logic [7:0]       payload [MAX_LEN];

  logic       to_hit_c;
  logic [8:0] tx_next_c;
  logic       tx_last_c;
  logic [7:0] next_byte_c;

`ifdef UART_RESP_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            rx_phase_c;

  // Inter-byte idle counter, only running while a frame is partially received.
  assign rx_phase_c = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign to_hit_c   = rx_phase_c && !rx_done_tick && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset || rx_done_tick || !rx_phase_c || to_hit_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign to_hit_c = 1'b0;
`endif

  // Byte that follows the one currently on w_data (index tx_cnt).
  always_comb begin
    tx_next_c   = tx_cnt + 9'd1;
    tx_last_c   = nak ? (tx_cnt == 9'd1) : (tx_cnt == (9'(len) + 9'd2));
    next_byte_c = xsum;
    if (nak) begin
      next_byte_c = nak_code;
    end else if (tx_next_c == 9'd1) begin
      next_byte_c = len;
    end else if (tx_next_c <= (9'(len) + 9'd1)) begin
      next_byte_c = payload[IDX_W'(tx_next_c - 9'd2)];
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state == S_DATA && rx_done_tick) begin
      payload[idx] <= r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_HUNT;
      tx_start  <= 1'b0;
      w_data    <= 8'h00;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      len       <= 8'h00;
      xsum      <= 8'h00;
      idx       <= '0;
      tx_cnt    <= 9'd0;
      nak       <= 1'b0;
      nak_code  <= 8'h00;
    end else begin
      tx_start  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (to_hit_c) begin
        // Silent abort: no NAK is transmitted.
        state     <= S_HUNT;
        busy      <= 1'b0;
        frame_err <= 1'b1;
      end else begin
        case (state)
          S_HUNT: begin
            if (rx_done_tick && r_data == SOF_REQ) begin
              state <= S_LEN;
              busy  <= 1'b1;
            end
          end
          S_LEN: begin
            if (rx_done_tick) begin
              if (r_data == 8'h00 || 32'(r_data) > MAX_LEN) begin
                state     <= S_TXWAIT;
                nak       <= 1'b1;
                nak_code  <= NAK_LEN;
                tx_cnt    <= 9'd0;
                tx_start  <= 1'b1;
                w_data    <= SOF_NAK;
                frame_err <= 1'b1;
              end else begin
                state <= S_DATA;
                len   <= r_data;
                xsum  <= r_data;
                idx   <= '0;
              end
            end
          end
          S_DATA: begin
            if (rx_done_tick) begin
              xsum <= xsum ^ r_data;
              idx  <= idx + IDX_W'(1);
              if (8'(idx) == len - 8'd1) begin
                state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (rx_done_tick) begin
              state    <= S_TXWAIT;
              tx_cnt   <= 9'd0;
              tx_start <= 1'b1;
              if (r_data == xsum) begin
                nak      <= 1'b0;
                w_data   <= SOF_RSP;
                frame_ok <= 1'b1;
              end else begin
                nak       <= 1'b1;
                nak_code  <= NAK_CSUM;
                w_data    <= SOF_NAK;
                frame_err <= 1'b1;
              end
            end
          end
          S_TXWAIT: begin
            // A done strobe coinciding with our own start pulse cannot
            // belong to the byte just requested.
            if (tx_done_tick && !tx_start) begin
              if (tx_last_c) begin
                state <= S_HUNT;
                busy  <= 1'b0;
              end else begin
                tx_cnt   <= tx_next_c;
                tx_start <= 1'b1;
                w_data   <= next_byte_c;
              end
            end
          end
          default: begin
            state <= S_HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder: drives request frames with random gaps,
// emulates the transmitter handshake with random byte times, and compares the
// transmitted bytes and status pulses with a frame-level reference model.
// The timeout scenario is included only when UART_RESP_TIMEOUT_EN is defined.
module tb_uart_cmd_responder;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 100;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] w_data;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] txq[$];
  int mon_ok   = 0;
  int mon_err  = 0;
  int mon_viol = 0;

  uart_cmd_responder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .r_data(r_data),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .w_data(w_data),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Transmitter emulation and handshake monitor (samples on the falling edge).
  initial begin : tx_emul
    logic       pending;
    logic       expect_next;
    logic       prev_start;
    logic [7:0] held;
    int         wait_cnt;
    pending = 1'b0; expect_next = 1'b0; prev_start = 1'b0; held = 8'h00; wait_cnt = 0;
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_tick = 1'b0;
      if (!reset) begin
        pending = 1'b0; expect_next = 1'b0; prev_start = 1'b0;
      end else begin
        if (frame_ok === 1'b1) mon_ok++;
        if (frame_err === 1'b1) mon_err++;
        // After a done strobe: either the next byte starts now or we are idle.
        if (expect_next && tx_start !== 1'b1 && busy !== 1'b0) mon_viol++;
        expect_next = 1'b0;
        if (tx_start === 1'b1) begin
          if (prev_start || pending) mon_viol++;
          txq.push_back(w_data);
          held = w_data;
          pending = 1'b1;
          wait_cnt = $urandom_range(1, 4);
        end else if (pending) begin
          if (w_data !== held) mon_viol++;
          wait_cnt--;
          if (wait_cnt == 0) begin
            tx_done_tick = 1'b1; pending = 1'b0; expect_next = 1'b1;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          tx_done_tick = 1'b1;  // stray strobe while nothing is being sent
        end
        prev_start = (tx_start === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Reference model: expected response bytes and pulse counts for one request stream.
  function automatic void model(input bq_t req, output bq_t rsp, output int n_ok, output int n_err);
    int i;
    int len;
    logic [7:0] x;
    rsp = {}; n_ok = 0; n_err = 0; i = 0;
    while (i < req.size() && req[i] != 8'hA5) i++;
    if (i + 1 >= req.size()) return;
    len = int'(req[i+1]);
    if (len == 0 || len > MAX_LEN) begin
      rsp.push_back(8'hEE); rsp.push_back(8'h02); n_err = 1; return;
    end
    if (i + 2 + len >= req.size()) return;
    x = req[i+1];
    for (int k = 0; k < len; k++) x ^= req[i+2+k];
    if (req[i+2+len] != x) begin
      rsp.push_back(8'hEE); rsp.push_back(8'h01); n_err = 1; return;
    end
    n_ok = 1;
    rsp.push_back(8'h5A);
    rsp.push_back(8'(len));
    for (int k = 0; k < len; k++) rsp.push_back(req[i+2+k]);
    rsp.push_back(x);
  endfunction

  function automatic bit same(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[k]) if (a[k] !== b[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    r_data = b; rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; r_data = 8'($urandom);
  endtask

  task automatic send_bytes(input bq_t q, input int gap);
    foreach (q[k]) begin
      send_byte(q[k]);
      if (k != q.size() - 1) repeat ($urandom_range(0, gap)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit expired);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    expired = (busy !== 1'b0);
  endtask

  // Sends a request stream and gathers what the responder did; no judgement here.
  task automatic run_frame(input bq_t req, output logic fs, output logic [7:0] fd, output bq_t got,
                           output int ok_d, output int err_d, output int v_d, output bit expired);
    int base, b_ok, b_err, b_v;
    base = txq.size(); b_ok = mon_ok; b_err = mon_err; b_v = mon_viol;
    send_bytes(req, 3);
    fs = tx_start; fd = w_data;
    wait_idle(expired);
    repeat (2) @(negedge clk);
    got = {};
    for (int k = base; k < txq.size(); k++) got.push_back(txq[k]);
    ok_d = mon_ok - b_ok; err_d = mon_err - b_err; v_d = mon_viol - b_v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    n_tests++; if (w_data !== 8'h00) begin n_fail++; $display("FAIL reset_w_data: got %h required 00", w_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: frame_ok=%b frame_err=%b required 0/0", frame_ok, frame_err);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: busy=%b tx_start=%b required 0/0", busy, tx_start);
    end
  endtask

  task automatic test_valid_frame();
    bq_t req, rest, exp, got;
    logic fs; logic [7:0] fd; int eok, eerr, okd, errd, vd; bit expd;
    req = '{8'h13, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    rest = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    model(req, exp, eok, eerr);
    send_byte(8'h13);
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL valid_ignore_noise: busy=%b required 0", busy); end
    send_byte(8'hA5);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL valid_busy_rise: busy=%b required 1", busy); end
    run_frame(rest, fs, fd, got, okd, errd, vd, expd);
    n_tests++; if (fs !== 1'b1 || fd !== exp[0]) begin n_fail++; $display("FAIL valid_first_tx: tx_start=%b w_data=%h required 1/%h", fs, fd, exp[0]); end
    n_tests++; if (!same(got, exp)) begin n_fail++; $display("FAIL valid_bytes: got %p required %p", got, exp); end
    n_tests++; if (okd != eok || errd != eerr) begin n_fail++; $display("FAIL valid_pulses: ok=%0d err=%0d required %0d/%0d", okd, errd, eok, eerr); end
    n_tests++; if (vd != 0 || expd) begin n_fail++; $display("FAIL valid_handshake: violations=%0d stuck=%0b required 0/0", vd, expd); end
  endtask

  task automatic test_checksum_error();
    bq_t req, exp, got;
    logic fs; logic [7:0] fd; int eok, eerr, okd, errd, vd; bit expd;
    req = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    model(req, exp, eok, eerr);
    run_frame(req, fs, fd, got, okd, errd, vd, expd);
    n_tests++; if (fs !== 1'b1 || fd !== exp[0]) begin n_fail++; $display("FAIL csum_first_tx: tx_start=%b w_data=%h required 1/%h", fs, fd, exp[0]); end
    n_tests++; if (!same(got, exp)) begin n_fail++; $display("FAIL csum_bytes: got %p required %p", got, exp); end
    n_tests++; if (okd != eok || errd != eerr) begin n_fail++; $display("FAIL csum_pulses: ok=%0d err=%0d required %0d/%0d", okd, errd, eok, eerr); end
    n_tests++; if (vd != 0 || expd) begin n_fail++; $display("FAIL csum_handshake: violations=%0d stuck=%0b required 0/0", vd, expd); end
  endtask

  task automatic test_length_errors();
    bq_t req, exp, got;
    logic fs; logic [7:0] fd; int eok, eerr, okd, errd, vd; bit expd;
    logic [7:0] lens [2];
    lens[0] = 8'h00; lens[1] = 8'(MAX_LEN + 1);
    for (int t = 0; t < 2; t++) begin
      req = {};
      req.push_back(8'hA5); req.push_back(lens[t]);
      model(req, exp, eok, eerr);
      run_frame(req, fs, fd, got, okd, errd, vd, expd);
      n_tests++; if (fs !== 1'b1 || fd !== exp[0]) begin n_fail++; $display("FAIL len%0d_first_tx: tx_start=%b w_data=%h required 1/%h", t, fs, fd, exp[0]); end
      n_tests++; if (!same(got, exp)) begin n_fail++; $display("FAIL len%0d_bytes: got %p required %p", t, got, exp); end
      n_tests++; if (okd != eok || errd != eerr) begin n_fail++; $display("FAIL len%0d_pulses: ok=%0d err=%0d required %0d/%0d", t, okd, errd, eok, eerr); end
      n_tests++; if (vd != 0 || expd) begin n_fail++; $display("FAIL len%0d_handshake: violations=%0d stuck=%0b required 0/0", t, vd, expd); end
    end
  endtask

  task automatic test_boundary_len();
    bq_t req, exp, got;
    logic fs; logic [7:0] fd; int eok, eerr, okd, errd, vd; bit expd;
    req = {};
    req.push_back(8'hA5); req.push_back(8'(MAX_LEN));
    for (int k = 0; k < MAX_LEN; k++) req.push_back(8'(k));
    req.push_back(8'h10);
    model(req, exp, eok, eerr);
    run_frame(req, fs, fd, got, okd, errd, vd, expd);
    n_tests++; if (got.size() != 19 || !same(got, exp)) begin n_fail++; $display("FAIL boundary_bytes: got %p required %p", got, exp); end
    n_tests++; if (okd != eok || errd != eerr) begin n_fail++; $display("FAIL boundary_pulses: ok=%0d err=%0d required %0d/%0d", okd, errd, eok, eerr); end
    n_tests++; if (vd != 0 || expd || fs !== 1'b1) begin n_fail++; $display("FAIL boundary_handshake: violations=%0d stuck=%0b first=%b required 0/0/1", vd, expd, fs); end
  endtask

  task automatic test_random_frames();
    bq_t req, exp, got;
    logic fs; logic [7:0] fd; int eok, eerr, okd, errd, vd; bit expd;
    for (int it = 0; it < 25; it++) begin
      int len;
      logic [7:0] x, g;
      req = {};
      repeat ($urandom_range(0, 2)) begin
        do g = 8'($urandom); while (g == 8'hA5);
        req.push_back(g);
      end
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      else len = int'($urandom_range(1, MAX_LEN));
      req.push_back(8'hA5); req.push_back(8'(len));
      if (len >= 1 && len <= MAX_LEN) begin
        x = 8'(len);
        for (int k = 0; k < len; k++) begin g = 8'($urandom); req.push_back(g); x ^= g; end
        if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
        req.push_back(x);
      end
      model(req, exp, eok, eerr);
      run_frame(req, fs, fd, got, okd, errd, vd, expd);
      n_tests++; if (fs !== 1'b1 || fd !== exp[0]) begin n_fail++; $display("FAIL rand%0d_first_tx: tx_start=%b w_data=%h required 1/%h", it, fs, fd, exp[0]); end
      n_tests++; if (!same(got, exp)) begin n_fail++; $display("FAIL rand%0d_bytes: got %p required %p", it, got, exp); end
      n_tests++; if (okd != eok || errd != eerr) begin n_fail++; $display("FAIL rand%0d_pulses: ok=%0d err=%0d required %0d/%0d", it, okd, errd, eok, eerr); end
      n_tests++; if (vd != 0 || expd) begin n_fail++; $display("FAIL rand%0d_handshake: violations=%0d stuck=%0b required 0/0", it, vd, expd); end
    end
  endtask

`ifdef UART_RESP_TIMEOUT_EN
  task automatic test_timeout();
    bq_t req, exp, got;
    logic fs; logic [7:0] fd; int eok, eerr, okd, errd, vd; bit expd;
    int base, b_err;
    base = txq.size(); b_err = mon_err;
    req = '{8'hA5, 8'h02, 8'h11};
    send_bytes(req, 2);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_partial_busy: busy=%b required 1", busy); end
    repeat (150) @(negedge clk);
    n_tests++; if (mon_err - b_err != 1 || txq.size() != base || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_abort: err=%0d tx=%0d busy=%b required 1/0/0", mon_err - b_err, txq.size() - base, busy);
    end
    req = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    model(req, exp, eok, eerr);
    run_frame(req, fs, fd, got, okd, errd, vd, expd);
    n_tests++; if (!same(got, exp) || okd != eok || vd != 0 || expd) begin
      n_fail++; $display("FAIL timeout_recover: got %p ok=%0d viol=%0d required %p ok=%0d viol=0", got, okd, vd, exp, eok);
    end
  endtask
`endif

  task automatic test_reset_mid_response();
    bq_t req, exp, got;
    logic fs; logic [7:0] fd; int eok, eerr, okd, errd, vd; bit expd;
    int base, n;
    req = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    base = txq.size();
    send_bytes(req, 2);
    n = 0;
    while (txq.size() - base < 3 && n < 500) begin @(negedge clk); n++; end
    n_tests++; if (txq.size() - base < 3) begin n_fail++; $display("FAIL midreset_reach_third: tx bytes=%0d required 3", txq.size() - base); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (tx_start !== 1'b0 || busy !== 1'b0 || w_data !== 8'h00) begin
      n_fail++; $display("FAIL midreset_outputs: tx_start=%b busy=%b w_data=%h required 0/0/00", tx_start, busy, w_data);
    end
    base = txq.size();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    n_tests++; if (txq.size() != base || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_quiet: extra tx=%0d busy=%b required 0/0", txq.size() - base, busy);
    end
    model(req, exp, eok, eerr);
    run_frame(req, fs, fd, got, okd, errd, vd, expd);
    n_tests++; if (!same(got, exp) || okd != eok || errd != eerr || vd != 0 || expd) begin
      n_fail++; $display("FAIL midreset_recover: got %p ok=%0d err=%0d viol=%0d required %p ok=%0d err=%0d viol=0", got, okd, errd, vd, exp, eok, eerr);
    end
  endtask

  initial begin : main
    test_reset();
    test_valid_frame();
    test_checksum_error();
    test_length_errors();
    test_boundary_len();
    test_random_frames();
`ifdef UART_RESP_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_response();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
